// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Owns the fetch PC, issues one
//               instruction-cache read at a time over a four-phase
//               read_enable/send_enable/send_complete handshake, buffers the
//               returned instructions in a small in-order queue and presents
//               them to decode over valid/ready. Redirects flush the queue and
//               retarget the PC; an in-flight cache transaction always runs to
//               completion and its result is dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int unsigned            ADDR_WIDTH  = 64,
    parameter int unsigned            INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = '0,
    parameter int unsigned            QUEUE_DEPTH = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    redirect_valid,
    input  logic [ADDR_WIDTH-1:0]   redirect_pc,
    output logic                    icache_read_enable,
    output logic [ADDR_WIDTH-1:0]   icache_address,
    output logic [2:0]              icache_data_size,
    output logic                    icache_send_complete,
    input  logic                    icache_send_enable,
    input  logic [63:0]             icache_data,
    output logic                    if_valid,
    output logic [INSTR_WIDTH-1:0]  if_instr,
    output logic [ADDR_WIDTH-1:0]   if_pc,
    input  logic                    id_ready
);

    localparam int unsigned              c_ptr_w = $clog2(QUEUE_DEPTH);
    localparam int unsigned              c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0]       c_depth = c_cnt_w'(QUEUE_DEPTH);
    localparam logic [ADDR_WIDTH-1:0]    c_step  = ADDR_WIDTH'(4);

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_REQ  = 2'd1,
        F_ACK  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0]   req_addr_q;
    logic                    discard_q, discard_d;
    logic [c_ptr_w-1:0]      head_q, head_d;
    logic [c_ptr_w-1:0]      tail_q, tail_d;
    logic [c_cnt_w-1:0]      count_q, count_d;
    logic [ADDR_WIDTH-1:0]   pc_mem_q    [QUEUE_DEPTH];
    logic [INSTR_WIDTH-1:0]  instr_mem_q [QUEUE_DEPTH];

    logic                    w_push;
    logic                    w_pop;
    logic                    w_start;
    logic                    w_ack_exit;
    logic [ADDR_WIDTH-1:0]   w_redirect_target;
    logic                    unused_bits;

    assign w_redirect_target = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    assign unused_bits       = ^{icache_data[63:INSTR_WIDTH], redirect_pc[1:0]};

    // Handshake outputs decoded from the state register only. The address is
    // held in its own register during a request so that a redirect arriving
    // mid-request never moves the address under the cache.
    assign icache_read_enable   = (state_q == F_REQ);
    assign icache_send_complete = (state_q == F_ACK);
    assign icache_address       = (state_q == F_REQ) ? req_addr_q : fetch_pc_q;
    assign icache_data_size     = 3'd4;

    assign if_valid = (count_q != '0);
    assign if_instr = if_valid ? instr_mem_q[head_q] : '0;
    assign if_pc    = if_valid ? pc_mem_q[head_q]    : '0;

    // A redirect overrides a decode pop in the same cycle.
    assign w_pop = if_valid && id_ready && !redirect_valid;

    // Next-state logic for the cache handshake, including capture strobes.
    always_comb begin
        state_d    = state_q;
        w_push     = 1'b0;
        w_start    = 1'b0;
        w_ack_exit = 1'b0;
        case (state_q)
            F_IDLE: begin
                if ((count_q < c_depth) && !redirect_valid) begin
                    state_d = F_REQ;
                    w_start = 1'b1;
                end
            end
            F_REQ: begin
                if (icache_send_enable) begin
                    state_d = F_ACK;
                    w_push  = !discard_q && !redirect_valid;
                end
            end
            F_ACK: begin
                if (!icache_send_enable) begin
                    state_d    = F_IDLE;
                    w_ack_exit = 1'b1;
                end
            end
            default: state_d = F_IDLE;
        endcase
    end

    // Next PC, discard flag and queue pointers; a redirect takes priority.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        discard_d  = discard_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;

        if (w_ack_exit) begin
            discard_d = 1'b0;
            if (!discard_q) begin
                fetch_pc_d = fetch_pc_q + c_step;
            end
        end

        if (w_push) begin
            tail_d = tail_q + c_ptr_w'(1);
        end
        if (w_pop) begin
            head_d = head_q + c_ptr_w'(1);
        end
        count_d = count_q + c_cnt_w'(w_push) - c_cnt_w'(w_pop);

        if (redirect_valid) begin
            fetch_pc_d = w_redirect_target;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            // Transaction still outstanding after this cycle: drop its result.
            if ((state_q == F_REQ) || ((state_q == F_ACK) && !w_ack_exit)) begin
                discard_d = 1'b1;
            end
        end
    end

    // State, PC and queue control registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= F_IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
            discard_q  <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            discard_q  <= discard_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            if (w_start) begin
                req_addr_q <= fetch_pc_q;
            end
        end
    end

    // Queue storage; contents are only visible through count, so no reset.
    always_ff @(posedge clock) begin
        if (w_push) begin
            pc_mem_q[tail_q]    <= fetch_pc_q;
            instr_mem_q[tail_q] <= icache_data[INSTR_WIDTH-1:0];
        end
    end

endmodule
`default_nettype wire
